// File: rtl/histogram_eq_engine.sv
// Two-pass histogram equalizer: pass 1 builds a histogram, the engine then forms the CDF
// and a mapping LUT with a restoring divider, and pass 2 remaps the same frame through the LUT.
module histogram_eq_engine #(
   parameter int PIX_W = 8,
   parameter int LANES = 16,
   parameter int CNT_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [15:0]              i_frame_beats,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [LANES*PIX_W-1:0]   i_in_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [LANES*PIX_W-1:0]   o_out_data,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_error,
   output logic [CNT_W-1:0]         o_cdf_min
);

   localparam int BINS  = 1 << PIX_W;
   localparam int LCW   = $clog2(LANES + 1);
   localparam int NUM_W = CNT_W + PIX_W;
   localparam int ITW   = $clog2(PIX_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_HIST, S_CDF, S_LUT, S_MAP, S_FIN} state_t;

   state_t                         r_state;
   state_t                         w_state_next;
   logic                           w_in_ready;
   logic [15:0]                    r_frame_beats;
   logic [15:0]                    r_beat_cnt;
   logic [PIX_W-1:0]               r_bin;
   logic [ITW-1:0]                 r_it;
   logic [CNT_W-1:0]               r_acc;
   logic [CNT_W-1:0]               r_cdf_min;
   logic                           r_min_found;
   logic [CNT_W-1:0]               r_rem;
   logic [PIX_W-1:0]               r_num_lo;
   logic [PIX_W-2:0]               r_quo;
   logic                           r_out_valid;
   logic [LANES*PIX_W-1:0]         r_out_data;
   logic                           r_error;
   logic [BINS-1:0][PIX_W-1:0]     r_lut;
   logic [BINS-1:0][CNT_W-1:0]     w_bin_cnt;

   logic [31:0]                    w_frame_pix;
   logic                           w_frame_bad;
   logic                           w_start_ok;
   logic                           w_start_bad;
   logic                           w_accept;
   logic                           w_hist_acc;
   logic [CNT_W-1:0]               w_cnt_k;
   logic [CNT_W-1:0]               w_cdf_new;
   logic [CNT_W-1:0]               w_den;
   logic [CNT_W-1:0]               w_diff;
   logic [NUM_W-1:0]               w_num;
   logic [CNT_W:0]                 w_shift;
   logic                           w_qbit;
   logic [CNT_W-1:0]               w_rem_next;
   logic [PIX_W-1:0]               w_quo;
   logic [PIX_W-1:0]               w_lut_val;

   assign w_frame_pix = 32'(i_frame_beats) * 32'(LANES);
   assign w_frame_bad = (i_frame_beats == 16'd0) || (w_frame_pix > 32'((1 << CNT_W) - 1));
   assign w_start_ok  = i_start && (r_state == S_IDLE) && !w_frame_bad;
   assign w_start_bad = i_start && (r_state == S_IDLE) && w_frame_bad;
   assign w_accept    = i_in_valid && w_in_ready;
   assign w_hist_acc  = w_accept && (r_state == S_HIST);

   // Histogram bins double as CDF storage once pass 1 is over.
   generate
      for (genvar gi = 0; gi < BINS; gi++) begin : g_bin
         logic [CNT_W-1:0] r_cnt;
         logic [LCW-1:0]   w_hit;

         always_comb begin
            w_hit = '0;
            for (int l = 0; l < LANES; l++) begin
               if (i_in_data[l*PIX_W +: PIX_W] == PIX_W'(gi)) begin
                  w_hit = w_hit + LCW'(1);
               end
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_cnt <= '0;
            end else if (w_start_ok) begin
               r_cnt <= '0;
            end else if (w_hist_acc) begin
               r_cnt <= r_cnt + CNT_W'(w_hit);
            end else if ((r_state == S_CDF) && (r_bin == PIX_W'(gi))) begin
               r_cnt <= w_cdf_new;
            end
         end

         assign w_bin_cnt[gi] = r_cnt;
      end
   endgenerate

   assign w_cnt_k   = w_bin_cnt[r_bin];
   assign w_cdf_new = r_acc + w_cnt_k;
   // After the CDF pass r_acc holds the frame's total pixel count.
   assign w_den     = r_acc - r_cdf_min;
   assign w_diff    = w_cnt_k - r_cdf_min;
   assign w_num     = NUM_W'(w_diff) * NUM_W'(BINS - 1);

   // Quotient fits in PIX_W bits, so the upper dividend bits already form a partial remainder below den.
   assign w_shift    = {r_rem, r_num_lo[PIX_W-1]};
   assign w_qbit     = (w_shift >= {1'b0, w_den});
   assign w_rem_next = w_qbit ? CNT_W'(w_shift - {1'b0, w_den}) : CNT_W'(w_shift);
   assign w_quo      = {r_quo, w_qbit};
   assign w_lut_val  = (w_cnt_k == '0) ? '0 :
                       (w_den == '0)   ? r_bin : w_quo;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_next = S_HIST;
         end
         S_HIST: begin
            w_in_ready = 1'b1;
            if (i_in_valid && (r_beat_cnt == r_frame_beats - 16'd1)) w_state_next = S_CDF;
         end
         S_CDF: begin
            if (r_bin == PIX_W'(BINS - 1)) w_state_next = S_LUT;
         end
         S_LUT: begin
            if ((r_it == ITW'(PIX_W)) && (r_bin == PIX_W'(BINS - 1))) w_state_next = S_MAP;
         end
         S_MAP: begin
            w_in_ready = (!r_out_valid || i_out_ready) && (r_beat_cnt != r_frame_beats);
            if ((r_beat_cnt == r_frame_beats) && r_out_valid && i_out_ready) w_state_next = S_FIN;
         end
         S_FIN: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_beats <= '0;
         r_beat_cnt    <= '0;
         r_bin         <= '0;
         r_it          <= '0;
         r_acc         <= '0;
         r_cdf_min     <= '0;
         r_min_found   <= 1'b0;
         r_rem         <= '0;
         r_num_lo      <= '0;
         r_quo         <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_error       <= 1'b0;
         r_lut         <= '0;
      end else begin
         r_error <= w_start_bad;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_frame_beats <= i_frame_beats;
                  r_beat_cnt    <= '0;
                  r_bin         <= '0;
                  r_it          <= '0;
                  r_acc         <= '0;
                  r_cdf_min     <= '0;
                  r_min_found   <= 1'b0;
                  r_out_valid   <= 1'b0;
               end
            end
            S_HIST: begin
               if (w_hist_acc) r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            S_CDF: begin
               r_acc <= w_cdf_new;
               r_bin <= r_bin + PIX_W'(1);
               if (!r_min_found && (w_cdf_new != '0)) begin
                  r_cdf_min   <= w_cdf_new;
                  r_min_found <= 1'b1;
               end
            end
            S_LUT: begin
               if (r_it == '0) begin
                  r_rem    <= w_num[NUM_W-1:PIX_W];
                  r_num_lo <= w_num[PIX_W-1:0];
                  r_it     <= ITW'(1);
               end else begin
                  r_rem    <= w_rem_next;
                  r_num_lo <= {r_num_lo[PIX_W-2:0], 1'b0};
                  r_quo    <= w_quo[PIX_W-2:0];
                  if (r_it == ITW'(PIX_W)) begin
                     r_lut[r_bin] <= w_lut_val;
                     r_bin        <= r_bin + PIX_W'(1);
                     r_it         <= '0;
                     r_beat_cnt   <= '0;
                  end else begin
                     r_it <= r_it + ITW'(1);
                  end
               end
            end
            S_MAP: begin
               if (w_accept) begin
                  for (int l = 0; l < LANES; l++) begin
                     r_out_data[l*PIX_W +: PIX_W] <= r_lut[i_in_data[l*PIX_W +: PIX_W]];
                  end
                  r_out_valid <= 1'b1;
                  r_beat_cnt  <= r_beat_cnt + 16'd1;
               end else if (i_out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_FIN);
   assign o_error     = r_error;
   assign o_cdf_min   = r_cdf_min;

endmodule

// File: tb/tb_histogram_eq_engine.sv
// Bench for histogram_eq_engine: directed frame table, rejected starts, random frames
// against an arithmetic equalization model, and a reset in the middle of the LUT build.
module tb_histogram_eq_engine;

   localparam int PIX_W = 8;
   localparam int LANES = 16;
   localparam int CNT_W = 16;
   localparam int DW    = LANES * PIX_W;
   localparam int MAXB  = 16;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_start;
   logic [15:0]      i_frame_beats;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [DW-1:0]    i_in_data;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [DW-1:0]    o_out_data;
   logic             o_busy;
   logic             o_done;
   logic             o_error;
   logic [CNT_W-1:0] o_cdf_min;

   histogram_eq_engine #(.PIX_W(PIX_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_frame_beats(i_frame_beats),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_cdf_min(o_cdf_min)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] frame_mem [MAXB];
   logic [DW-1:0] exp_mem   [MAXB];
   int            exp_cdf_min;
   logic [DW-1:0] first_out;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Equalization computed straight from the histogram/CDF formulas.
   function automatic void build_model(input int nb);
      int hist [256];
      int cdf  [256];
      int lut  [256];
      int cmin, den, run, pv;
      for (int k = 0; k < 256; k++) hist[k] = 0;
      for (int b = 0; b < nb; b++)
         for (int l = 0; l < LANES; l++) begin
            pv = int'(frame_mem[b][l*PIX_W +: PIX_W]);
            hist[pv]++;
         end
      run  = 0;
      cmin = 0;
      for (int k = 0; k < 256; k++) begin
         run    = run + hist[k];
         cdf[k] = run;
         if (cmin == 0 && run != 0) cmin = run;
      end
      den = run - cmin;
      for (int k = 0; k < 256; k++) begin
         if (cdf[k] == 0)  lut[k] = 0;
         else if (den == 0) lut[k] = k;
         else              lut[k] = ((cdf[k] - cmin) * 255) / den;
      end
      exp_cdf_min = cmin;
      for (int b = 0; b < nb; b++)
         for (int l = 0; l < LANES; l++) begin
            pv = int'(frame_mem[b][l*PIX_W +: PIX_W]);
            exp_mem[b][l*PIX_W +: PIX_W] = 8'(lut[pv]);
         end
   endfunction

   function automatic void fill_frame(input int kind, input int nb);
      int sel, a, c, d;
      sel = int'($urandom_range(0, 2));
      a   = int'($urandom_range(0, 255));
      c   = int'($urandom_range(0, 255));
      d   = int'($urandom_range(0, 255));
      for (int b = 0; b < nb; b++)
         for (int l = 0; l < LANES; l++) begin
            case (kind)
               0: frame_mem[b][l*PIX_W +: PIX_W] = 8'h40;
               1: frame_mem[b][l*PIX_W +: PIX_W] = 8'(16 * l);
               2: frame_mem[b][l*PIX_W +: PIX_W] = (((l + b) % 2) != 0) ? 8'd200 : 8'd10;
               3: frame_mem[b][l*PIX_W +: PIX_W] = 8'h00;
               default: begin
                  if (sel == 0)      frame_mem[b][l*PIX_W +: PIX_W] = 8'($urandom_range(0, 255));
                  else if (sel == 1) frame_mem[b][l*PIX_W +: PIX_W] = ($urandom_range(0, 2) == 0) ? 8'(a) :
                                                                      ($urandom_range(0, 1) == 0) ? 8'(c) : 8'(d);
                  else               frame_mem[b][l*PIX_W +: PIX_W] = 8'(a);
               end
            endcase
         end
   endfunction

   // rmode: 0 = out_ready always 1, 1 = out_ready pattern 1,0,0,1, 2 = random ready and input gaps
   task automatic run_frame(input int nb, input int rmode);
      int   cyc, phase, in_idx, out_idx, last_acc;
      logic ir, prev_stall;
      logic [DW-1:0] prev_data;
      build_model(nb);
      cyc = 0; phase = 0; in_idx = 0; out_idx = 0; last_acc = 0;
      prev_stall = 1'b0; prev_data = '0;
      @(negedge i_clk);
      i_start       = 1'b1;
      i_frame_beats = 16'(nb);
      while (out_idx < nb && cyc < 6000) begin
         @(negedge i_clk);
         i_start = 1'b0;
         case (phase)
            0: begin
               i_in_valid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
               i_in_data  = frame_mem[in_idx];
            end
            1: begin
               i_in_valid = 1'b1;
               i_in_data  = frame_mem[0];
            end
            default: begin
               i_in_valid = (in_idx < nb) && ((rmode != 2) || ($urandom_range(0, 3) != 0));
               i_in_data  = (in_idx < nb) ? frame_mem[in_idx] : '0;
            end
         endcase
         if (rmode == 0)      i_out_ready = 1'b1;
         else if (rmode == 1) i_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else                 i_out_ready = 1'($urandom_range(0, 1));
         #1;
         ir = o_in_ready;
         if (prev_stall) begin
            check("stall_data_stable", o_out_data, prev_data);
            check("stall_valid_held", DW'(o_out_valid), DW'(1));
         end
         if (o_out_valid && !i_out_ready) begin
            check("stall_in_ready_low", DW'(ir), DW'(0));
            prev_stall = 1'b1;
            prev_data  = o_out_data;
         end else begin
            prev_stall = 1'b0;
         end
         if (o_out_valid && i_out_ready) begin
            check($sformatf("out_beat%0d", out_idx), o_out_data, exp_mem[out_idx]);
            if (out_idx == 0) first_out = o_out_data;
            out_idx++;
         end
         case (phase)
            0: begin
               if (i_in_valid && ir) begin
                  in_idx++;
                  if (in_idx == nb) begin
                     phase    = 1;
                     last_acc = cyc;
                  end
               end
            end
            1: begin
               if (cyc == last_acc + 1) check("in_ready_drop_after_hist", DW'(ir), DW'(0));
               if (ir) begin
                  check("map_ready_latency", DW'(cyc - last_acc), DW'(2561));
                  phase  = 2;
                  in_idx = 1;
               end
            end
            default: begin
               if (i_in_valid && ir) in_idx++;
            end
         endcase
         cyc++;
      end
      i_in_valid  = 1'b0;
      if (cyc >= 6000) check("frame_timeout", DW'(1), DW'(0));
      @(negedge i_clk);
      i_out_ready = 1'b0;
      #1;
      check("done_pulse", DW'(o_done), DW'(1));
      check("busy_in_fin", DW'(o_busy), DW'(1));
      check("cdf_min_model", DW'(o_cdf_min), DW'(exp_cdf_min));
      @(negedge i_clk);
      #1;
      check("done_cleared", DW'(o_done), DW'(0));
      check("busy_cleared", DW'(o_busy), DW'(0));
   endtask

   typedef struct {
      int         kind;
      int         beats;
      int         rmode;
      int         exp_cdf_min;
      logic [7:0] exp_l0;
      logic [7:0] exp_l15;
   } fvec_t;

   typedef struct {
      int   fb;
      logic exp_err;
   } svec_t;

   fvec_t fv [4];
   svec_t sv [3];

   initial begin
      fv[0] = '{kind: 0, beats: 1, rmode: 0, exp_cdf_min: 16, exp_l0: 8'h40, exp_l15: 8'h40};
      fv[1] = '{kind: 1, beats: 1, rmode: 0, exp_cdf_min: 1,  exp_l0: 8'h00, exp_l15: 8'hFF};
      fv[2] = '{kind: 2, beats: 4, rmode: 1, exp_cdf_min: 32, exp_l0: 8'h00, exp_l15: 8'hFF};
      fv[3] = '{kind: 2, beats: 4, rmode: 0, exp_cdf_min: 32, exp_l0: 8'h00, exp_l15: 8'hFF};
      sv[0] = '{fb: 0,     exp_err: 1'b1};
      sv[1] = '{fb: 4096,  exp_err: 1'b1};
      sv[2] = '{fb: 65535, exp_err: 1'b1};

      i_rst_n = 1'b1; i_start = 1'b0; i_frame_beats = '0;
      i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0; first_out = '0;
      #3 i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst_busy", DW'(o_busy), DW'(0));
      check("rst_in_ready", DW'(o_in_ready), DW'(0));
      check("rst_out_valid", DW'(o_out_valid), DW'(0));
      check("rst_out_data", o_out_data, DW'(0));
      check("rst_done_error", DW'({o_done, o_error}), DW'(0));
      check("rst_cdf_min", DW'(o_cdf_min), DW'(0));
      i_rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         i_start = 1'b1; i_frame_beats = 16'(sv[i].fb);
         @(negedge i_clk);
         i_start = 1'b0;
         check($sformatf("reject_err_fb%0d", sv[i].fb), DW'(o_error), DW'(sv[i].exp_err));
         check($sformatf("reject_busy_fb%0d", sv[i].fb), DW'(o_busy), DW'(0));
         @(negedge i_clk);
         check($sformatf("reject_err_clear_fb%0d", sv[i].fb), DW'(o_error), DW'(0));
      end

      for (int i = 0; i < 4; i++) begin
         fill_frame(fv[i].kind, fv[i].beats);
         run_frame(fv[i].beats, fv[i].rmode);
         check($sformatf("vec%0d_cdf_min", i), DW'(o_cdf_min), DW'(fv[i].exp_cdf_min));
         check($sformatf("vec%0d_lane0", i), DW'(first_out[7:0]), DW'(fv[i].exp_l0));
         check($sformatf("vec%0d_lane15", i), DW'(first_out[DW-1 -: 8]), DW'(fv[i].exp_l15));
      end

      for (int i = 0; i < 5; i++) begin
         int nb;
         nb = int'($urandom_range(1, 8));
         fill_frame(9, nb);
         run_frame(nb, 2);
      end

      // Reset in the middle of the LUT build, then a fresh all-zero frame.
      @(negedge i_clk);
      i_start = 1'b1; i_frame_beats = 16'd1;
      i_in_valid = 1'b1; i_in_data = {LANES{8'h77}};
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      i_in_valid = 1'b0;
      repeat (600) @(negedge i_clk);
      check("midlut_busy", DW'(o_busy), DW'(1));
      i_start = 1'b1; i_frame_beats = 16'd0;
      @(negedge i_clk);
      i_start = 1'b0;
      check("start_while_busy_no_error", DW'(o_error), DW'(0));
      check("midlut_cdf_min", DW'(o_cdf_min), DW'(16));
      i_rst_n = 1'b0;
      #1;
      check("midrst_busy", DW'(o_busy), DW'(0));
      check("midrst_cdf_min", DW'(o_cdf_min), DW'(0));
      @(negedge i_clk);
      i_rst_n = 1'b1;
      fill_frame(3, 1);
      run_frame(1, 0);
      check("zero_cdf_min", DW'(o_cdf_min), DW'(16));
      check("zero_out", first_out, DW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/histogram_eq_engine.md
Name: histogram_eq_engine

Overview:
- Parametrised, self-sequencing successor to the three-stage equalizer core (histogram, CDF, divider). One module, one FSM.
- Pass 1 streams a frame of LANES-pixel beats and accumulates an internal histogram.
- It then builds the CDF, finds cdf_min at runtime (no longer hardwired), and builds a mapping LUT with a sequential divider.
- Pass 2 streams the same frame back in and emits equalized pixels over a valid/ready interface. It sits between the input/output memory controllers and the master FSM.

Parameters:
- PIX_W, 8, pixel width in bits; BINS = 2^PIX_W.
- LANES, 16, pixels per beat; data bus is LANES*PIX_W bits wide.
- CNT_W, 16, width of the bin, CDF and total-pixel counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored unless FSM is in IDLE.
- frame_beats  in  16  beats per frame; sampled on accepted start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  LANES*PIX_W  lane k = bits [k*PIX_W +: PIX_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*PIX_W  equalized pixels, same lane order as in_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- error  out  1  one-cycle pulse when a start is rejected.
- cdf_min  out  CNT_W  first nonzero CDF value of the current frame.

Behaviour:
- Reset values: all outputs 0; FSM to IDLE; histogram, LUT and counters cleared.
- States: IDLE, HIST, CDF, LUT, MAP, FIN.
- IDLE, on start:
  - Reject with an error pulse next cycle, staying in IDLE, if frame_beats==0 or frame_beats*LANES > 2^CNT_W-1.
  - Otherwise latch frame_beats, clear all BINS histogram entries in the same edge, beat_cnt=0, go to HIST.
- HIST:
  - in_ready=1.
  - Each accepted beat adds to every bin b the number of lanes equal to b; several lanes hitting one bin in one beat must all count.
  - After frame_beats accepted beats go to CDF; in_ready drops the cycle after the last beat.
- CDF:
  - One bin per cycle, k=0..BINS-1; cdf[k] = cdf[k-1] + hist[k], stored in place.
  - cdf_min latches at the first k with cdf[k] != 0.
  - Exactly BINS cycles, then LUT.
- LUT:
  - Per bin: den = total - cdf_min; num = (cdf[k] - cdf_min)*(BINS-1), width CNT_W+PIX_W.
  - Restoring divider: 1 load cycle plus PIX_W iterations, giving a PIX_W-bit floor quotient.
  - lut[k] = 0 if cdf[k]==0.
  - If den==0 (single-valued frame), lut[k] = k, i.e. identity.
  - Total BINS*(PIX_W+1) cycles, then MAP with beat_cnt=0.
- MAP:
  - in_ready = !out_valid | out_ready (1-deep registered output).
  - An accepted beat registers out_data lane k = lut[in lane k] and sets out_valid on the next edge.
  - out_valid holds and out_data is stable until out_ready.
  - After frame_beats accepted beats and the final output handshake, go to FIN.
- FIN: done=1 for one cycle, then IDLE. busy falls on the same edge as done falls.
- start while busy: ignored; no error.
- in_valid outside HIST/MAP: ignored (in_ready=0).
- Reset asserted mid-operation: immediate clear to reset values; next start begins a fresh histogram.

Test Plan:
- PIX_W=8, LANES=16; frame_beats=1, all lanes 0x40 → cdf_min=16, den=0 → identity; MAP output all lanes 0x40; done 1 cycle.
- frame_beats=1, lane i = 16*i (0..240) → cdf_min=1, den=15; MAP output lane i = 17*i (0x00,0x11,...,0xFF).
- frame_beats=4, 32 pixels=10 and 32 pixels=200, mixed within beats → hist[10]=32, hist[200]=32, cdf_min=32, lut[10]=0, lut[200]=255.
- Timing, same frame as the previous scenario: in_ready falls after beat 4; MAP in_ready rises exactly 256 + 256*9 = 2560 cycles after CDF entry.
- MAP with out_ready toggling 1,0,0,1 and in_valid always high → every beat is output exactly once in order; in_ready=0 whenever out_valid & !out_ready; out_data is stable while stalled.
- start with frame_beats=0, then with 4096 (65536 pixels) → error pulse each time, busy stays 0.
- Repeat with a valid start, drive reset low mid-LUT, release, start a new frame of all 0x00 → outputs 0x00, cdf_min=16.
